// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module      : imm_decode_stage
// Description : Registered immediate-decode stage between fetch and execute.
//               Classifies the opcode, builds the sign-extended immediate and
//               the PC-relative target behind a single-entry valid/ready slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
);

    localparam logic [2:0] c_FMT_R       = 3'd0;
    localparam logic [2:0] c_FMT_I       = 3'd1;
    localparam logic [2:0] c_FMT_S       = 3'd2;
    localparam logic [2:0] c_FMT_B       = 3'd3;
    localparam logic [2:0] c_FMT_U       = 3'd4;
    localparam logic [2:0] c_FMT_J       = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT   = 3'd6;
    localparam logic [2:0] c_FMT_ILLEGAL = 3'd7;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_target;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Compressed encodings (inst[1:0] != 11) never match a listed opcode,
    // so they fall through to ILLEGAL without a separate check.
    always_comb begin
        w_fmt = c_FMT_ILLEGAL;
        case (w_opcode)
            c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: w_fmt = c_FMT_I;
            c_OP_IMM: w_fmt = (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                              ? c_FMT_SHAMT : c_FMT_I;
            c_OP_STORE:            w_fmt = c_FMT_S;
            c_OP_BRANCH:           w_fmt = c_FMT_B;
            c_OP_LUI, c_OP_AUIPC:  w_fmt = c_FMT_U;
            c_OP_JAL:              w_fmt = c_FMT_J;
            c_OP_OP:               w_fmt = c_FMT_R;
            default:               w_fmt = c_FMT_ILLEGAL;
        endcase
    end

    // Size-casting a signed operand sign-extends it to XLEN.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            c_FMT_I: w_imm = XLEN'($signed(in_inst[31:20]));
            c_FMT_S: w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            c_FMT_B: w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0}));
            c_FMT_U: w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            c_FMT_J: w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0}));
            c_FMT_SHAMT: w_imm = XLEN'(in_inst[20 +: SHAMT_W]);
            default: w_imm = '0;
        endcase
    end

    assign w_target = in_pc + w_imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_fmt     <= c_FMT_R;
            r_illegal <= 1'b0;
            r_pc      <= '0;
            r_target  <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= (w_fmt == c_FMT_ILLEGAL);
            r_pc      <= in_pc;
            r_target  <= w_target;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_imm     = r_imm;
    assign out_fmt     = r_fmt;
    assign out_illegal = r_illegal;
    assign out_pc      = r_pc;
    assign out_target  = r_target;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Scoreboard bench for imm_decode_stage (XLEN=32 plus an
//               XLEN=64 instance for upper-word sign extension).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [31:0] out_target;

    logic        v64_in_valid;
    logic        v64_in_ready;
    logic [31:0] v64_in_inst;
    logic [63:0] v64_in_pc;
    logic        v64_out_valid;
    logic [63:0] v64_out_imm;
    logic [2:0]  v64_out_fmt;
    logic        v64_out_illegal;
    logic [63:0] v64_out_pc;
    logic [63:0] v64_out_target;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   pop_cyc[$];
    exp_t snap;
    bit   prev_stall = 1'b0;

    imm_decode_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_pc(out_pc), .out_target(out_target)
    );

    imm_decode_stage #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_inst(v64_in_inst), .in_pc(v64_in_pc), .out_valid(v64_out_valid),
        .out_ready(1'b1), .out_imm(v64_out_imm), .out_fmt(v64_out_fmt),
        .out_illegal(v64_out_illegal), .out_pc(v64_out_pc),
        .out_target(v64_out_target)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every consumed output, checks hold-stability in stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else if (!out_valid) begin
            chk("in_ready_idle", in_ready, 1);
            prev_stall = 1'b0;
        end else if (out_ready) begin
            chk("in_ready_consume", in_ready, 1);
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                pop_cyc.push_back(cyc);
                chk("imm", out_imm, e.imm);
                chk("fmt", out_fmt, e.fmt);
                chk("illegal", out_illegal, e.ill);
                chk("pc", out_pc, e.pc);
                chk("target", out_target, e.tgt);
            end
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_stall", in_ready, 0);
            if (prev_stall) begin
                chk("stall_imm", out_imm, snap.imm);
                chk("stall_fmt", out_fmt, snap.fmt);
                chk("stall_pc", out_pc, snap.pc);
                chk("stall_target", out_target, snap.tgt);
            end
            snap = '{out_imm, out_fmt, out_illegal, out_pc, out_target};
            prev_stall = 1'b1;
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        exp_t e;
        bit   acc;
        int   n;
        e = '{imm, fmt, ill, pc, pc + imm};
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) sb.push_back(e);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int s;
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        v64_in_valid = 1'b0; v64_in_inst = '0; v64_in_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_fmt", out_fmt, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_target", out_target, 0);
        chk("rst_in_ready", in_ready, 1);

        // XLEN=64 upper-word replication of a U immediate
        @(posedge clk); #1;
        v64_in_valid = 1'b1; v64_in_inst = 32'h800000B7; v64_in_pc = 64'h0;
        @(negedge clk);
        chk("x64_in_ready", v64_in_ready, 1);
        @(posedge clk); #1;
        v64_in_valid = 1'b0;
        @(negedge clk);
        chk("x64_valid", v64_out_valid, 1);
        chk("x64_imm", v64_out_imm, 64'hFFFFFFFF80000000);
        chk("x64_fmt", v64_out_fmt, 4);
        chk("x64_illegal", v64_out_illegal, 0);
        chk("x64_pc", v64_out_pc, 0);
        chk("x64_target", v64_out_target, 64'hFFFFFFFF80000000);
        @(posedge clk); #1;

        // Directed decode vectors, streamed back-to-back with out_ready=1
        send(32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, 3'd1, 1'b0); // addi -1
        send(32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, 3'd3, 1'b0); // beq -4
        send(32'h123450B7, 32'h0000_0200, 32'h12345000, 3'd4, 1'b0); // lui
        send(32'h4030D093, 32'h0000_0010, 32'h00000003, 3'd6, 1'b0); // srai 3
        send(32'h0000007F, 32'h0000_0040, 32'h00000000, 3'd7, 1'b1); // bad opcode
        send(32'hFE20AC23, 32'h0000_1000, 32'hFFFFFFF8, 3'd2, 1'b0); // sw -8
        send(32'h001000EF, 32'hFFFF_F900, 32'h00000800, 3'd5, 1'b0); // jal wraps
        send(32'h002081B3, 32'h0000_0008, 32'h00000000, 3'd0, 1'b0); // add
        send(32'h00004501, 32'h0000_0020, 32'h00000000, 3'd7, 1'b1); // compressed
        send(32'hFFFFF117, 32'h0000_3000, 32'hFFFFF000, 3'd4, 1'b0); // auipc
        send(32'h01F09093, 32'h0000_0004, 32'h0000001F, 3'd6, 1'b0); // slli 31
        send(32'h00000073, 32'h0000_0050, 32'h00000000, 3'd1, 1'b0); // ecall
        send(32'h7FF02083, 32'h0000_0060, 32'h000007FF, 3'd1, 1'b0); // lw 0x7ff
        send(32'h000080E7, 32'h0000_0070, 32'h00000000, 3'd1, 1'b0); // jalr
        drain();

        // Back-pressure: 3-cycle stall after the first of 4 streamed entries
        s = pop_cyc.size();
        out_ready = 1'b0;
        fork
            begin
                send(32'h00100093, 32'h0, 32'h1, 3'd1, 1'b0);
                send(32'h00200093, 32'h4, 32'h2, 3'd1, 1'b0);
                send(32'h00300093, 32'h8, 32'h3, 3'd1, 1'b0);
                send(32'h00400093, 32'hC, 32'h4, 3'd1, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", pop_cyc.size() - s, 4);
        if (pop_cyc.size() - s == 4) begin
            for (int i = 0; i < 3; i++)
                chk("bp_one_per_cycle", pop_cyc[s+i+1] - pop_cyc[s+i], 1);
        end

        // Reset while an entry is held under back-pressure
        out_ready = 1'b0;
        send(32'h00500093, 32'h80, 32'h5, 3'd1, 1'b0);
        @(negedge clk);
        chk("held_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_imm", out_imm, 0);
        chk("mid_rst_fmt", out_fmt, 0);
        chk("mid_rst_illegal", out_illegal, 0);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_target", out_target, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
